// File: rtl/convpress_decomp_node_d1.sv
// Compressed-beat expander: merges (index, value) pairs into a dense
// Tn-lane brick and hands it to NBin with a transmitted-lane mask.
module convpress_decomp_node_d1 #(
  parameter int N         = 16,
  parameter int Tn        = 16,
  parameter int OFFSET_SZ = 4,
  parameter int CNT_SZ    = 5,
  parameter int BCNT_SZ   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [Tn*N-1:0]         i_data,
  input  logic [Tn*OFFSET_SZ-1:0] i_idx,
  input  logic [CNT_SZ-1:0]       i_cnt,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [Tn*N-1:0]         o_data,
  output logic [Tn-1:0]           o_mask,
  output logic                    o_err,
  output logic [BCNT_SZ-1:0]      o_brick_cnt
);

  typedef enum logic {ACCUM, FULL} state_t;

  state_t state_q, state_d;

  logic [Tn-1:0][N-1:0] acc_data_q, acc_data_d;
  logic [Tn-1:0][N-1:0] out_data_q, out_data_d;
  logic [Tn-1:0][N-1:0] mrg_data;
  logic [Tn-1:0]        acc_mask_q, acc_mask_d;
  logic [Tn-1:0]        out_mask_q, out_mask_d;
  logic [Tn-1:0]        mrg_mask;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [BCNT_SZ-1:0]   bcnt_q, bcnt_d;

  logic                 over;
  logic                 dup;
  logic [CNT_SZ-1:0]    cnt_eff;
  logic [OFFSET_SZ-1:0] lane;
  logic                 fire;
  logic                 drain;

  assign o_ready     = (state_q == ACCUM);
  assign o_valid     = valid_q;
  assign o_data      = out_data_q;
  assign o_mask      = out_mask_q;
  assign o_err       = err_q;
  assign o_brick_cnt = bcnt_q;

  assign fire  = i_valid && o_ready;
  assign drain = valid_q && i_ready;

  // Seeding the merge mask with acc catches repeats across beats too
  always_comb begin
    over     = (i_cnt > CNT_SZ'(Tn));
    cnt_eff  = over ? CNT_SZ'(Tn) : i_cnt;
    mrg_data = acc_data_q;
    mrg_mask = acc_mask_q;
    dup      = 1'b0;
    lane     = '0;
    for (int k = 0; k < Tn; k++) begin
      if (CNT_SZ'(k) < cnt_eff) begin
        lane = i_idx[k*OFFSET_SZ +: OFFSET_SZ];
        if (mrg_mask[lane]) dup = 1'b1;
        mrg_mask[lane] = 1'b1;
        mrg_data[lane] = i_data[k*N +: N];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    valid_d    = valid_q;
    err_d      = err_q;
    bcnt_d     = bcnt_q;

    if (drain) valid_d = 1'b0;

    unique case (state_q)
      ACCUM: begin
        if (fire) begin
          if (over || dup) err_d = 1'b1;
          if (!i_last) begin
            acc_data_d = mrg_data;
            acc_mask_d = mrg_mask;
          end else if (!valid_q || i_ready) begin
            out_data_d = mrg_data;
            out_mask_d = mrg_mask;
            valid_d    = 1'b1;
            bcnt_d     = bcnt_q + BCNT_SZ'(1);
            acc_data_d = '0;
            acc_mask_d = '0;
          end else begin
            acc_data_d = mrg_data;
            acc_mask_d = mrg_mask;
            state_d    = FULL;
          end
        end
      end
      FULL: begin
        if (drain) begin
          out_data_d = acc_data_q;
          out_mask_d = acc_mask_q;
          valid_d    = 1'b1;
          bcnt_d     = bcnt_q + BCNT_SZ'(1);
          acc_data_d = '0;
          acc_mask_d = '0;
          state_d    = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      bcnt_q     <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_convpress_decomp_node_d1.sv
// Bench for convpress_decomp_node_d1: pending-brick queue model plus
// directed literal checks and a randomized run.
module tb_convpress_decomp_node_d1;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int OS = 4;
  localparam int CS = 5;
  localparam int BS = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [TN*N-1:0] i_data = '0;
  logic [TN*OS-1:0] i_idx = '0;
  logic [CS-1:0]   i_cnt = '0;
  logic            i_last = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic [TN*N-1:0] o_data;
  logic [TN-1:0]   o_mask;
  logic            o_err;
  logic [BS-1:0]   o_brick_cnt;

  convpress_decomp_node_d1 dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_idx(i_idx), .i_cnt(i_cnt), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_mask(o_mask),
    .o_err(o_err), .o_brick_cnt(o_brick_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [TN*N-1:0] d;
    logic [TN-1:0]   m;
  } brick_t;

  // Model: bricks completed but not yet taken; q[0] is what NBin sees
  brick_t          q[$];
  logic [TN*N-1:0] m_acc_d = '0;
  logic [TN-1:0]   m_acc_m = '0;
  int unsigned     consumed = 0;
  logic            m_err = 1'b0;
  bit              chk_en = 1'b0;
  logic [TN-1:0]   emitted[$];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit acc_ok;
    int c;
    int ln;
    if (chk_en) begin
      chk("valid", o_valid, q.size() > 0);
      chk("ready", o_ready, q.size() < 2);
      chk("err", o_err, m_err);
      chk("bcnt", o_brick_cnt, BS'(consumed + (q.size() > 0 ? 1 : 0)));
      if (q.size() > 0) begin
        chk("data", o_data, q[0].d);
        chk("mask", o_mask, q[0].m);
      end
    end
    if (o_valid && i_ready && !rst) emitted.push_back(o_mask);
    if (rst) begin
      q.delete();
      m_acc_d  = '0;
      m_acc_m  = '0;
      consumed = 0;
      m_err    = 1'b0;
    end else begin
      acc_ok = i_valid && (q.size() < 2);
      if (q.size() > 0 && i_ready) begin
        void'(q.pop_front());
        consumed++;
      end
      if (acc_ok) begin
        c = (i_cnt > 16) ? 16 : int'(i_cnt);
        if (i_cnt > 16) m_err = 1'b1;
        for (int k = 0; k < c; k++) begin
          ln = int'(i_idx[k*OS +: OS]);
          if (m_acc_m[ln]) m_err = 1'b1;
          m_acc_m[ln] = 1'b1;
          m_acc_d[ln*N +: N] = i_data[k*N +: N];
        end
        if (i_last) begin
          q.push_back('{m_acc_d, m_acc_m});
          m_acc_d = '0;
          m_acc_m = '0;
        end
      end
    end
  end

  task automatic clr_pairs();
    i_idx  = '0;
    i_data = '0;
  endtask

  task automatic pair(input int k, input int idx, input logic [N-1:0] d);
    i_idx[k*OS +: OS] = OS'(idx);
    i_data[k*N +: N]  = d;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got o_ready=0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Pairs must be preloaded with clr_pairs/pair before calling
  task automatic send(input int cnt, input bit last);
    i_cnt   = CS'(cnt);
    i_last  = last;
    i_valid = 1'b1;
    wait_accept();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [TN*N-1:0] exp_d;
    bit took;
    int st;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_mask", o_mask, '0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_bcnt", o_brick_cnt, '0);
    chk_en = 1'b1;

    // Single beat brick
    @(posedge clk);
    #1 i_ready = 1'b1;
    clr_pairs();
    pair(0, 2, 16'h0011);
    pair(1, 5, 16'h0022);
    pair(2, 15, 16'h0033);
    send(3, 1'b1);
    @(negedge clk);
    exp_d = '0;
    exp_d[2*N +: N]  = 16'h0011;
    exp_d[5*N +: N]  = 16'h0022;
    exp_d[15*N +: N] = 16'h0033;
    chk("t1_valid", o_valid, 1'b1);
    chk("t1_mask", o_mask, 16'h8024);
    chk("t1_data", o_data, exp_d);
    chk("t1_bcnt", o_brick_cnt, 16'd1);
    chk("t1_err", o_err, 1'b0);

    // Two-beat brick
    do_reset();
    clr_pairs();
    pair(0, 0, 16'd1);
    pair(1, 1, 16'd2);
    send(2, 1'b0);
    clr_pairs();
    pair(0, 15, 16'd7);
    send(1, 1'b1);
    @(negedge clk);
    exp_d = '0;
    exp_d[0 +: N]     = 16'd1;
    exp_d[N +: N]     = 16'd2;
    exp_d[15*N +: N]  = 16'd7;
    chk("t2_mask", o_mask, 16'h8003);
    chk("t2_data", o_data, exp_d);
    chk("t2_bcnt", o_brick_cnt, 16'd1);

    // Back-pressure: three bricks with NBin stalled
    do_reset();
    i_ready = 1'b0;
    emitted.delete();
    clr_pairs();
    pair(0, 1, 16'hA1);
    send(1, 1'b1);
    clr_pairs();
    pair(0, 2, 16'hA2);
    send(1, 1'b1);
    @(posedge clk);
    #1 clr_pairs();
    pair(0, 3, 16'hA3);
    i_cnt   = 5'd1;
    i_last  = 1'b1;
    i_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_ready", o_ready, 1'b0);
    chk("t3_bcnt_hold", o_brick_cnt, 16'd1);
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_accept();
    repeat (4) @(negedge clk);
    chk("t3_bcnt", o_brick_cnt, 16'd3);
    chk("t3_n_out", emitted.size(), 3);
    if (emitted.size() == 3) begin
      chk("t3_ord0", emitted[0], 16'h0002);
      chk("t3_ord1", emitted[1], 16'h0004);
      chk("t3_ord2", emitted[2], 16'h0008);
    end

    // Empty brick, then duplicate lane in one beat
    clr_pairs();
    send(0, 1'b1);
    @(negedge clk);
    chk("t4_valid", o_valid, 1'b1);
    chk("t4_data0", o_data, '0);
    chk("t4_mask0", o_mask, '0);
    chk("t4_err0", o_err, 1'b0);
    clr_pairs();
    pair(0, 4, 16'd9);
    pair(1, 4, 16'd8);
    send(2, 1'b1);
    @(negedge clk);
    chk("t4_lane4", o_data[4*N +: N], 16'd8);
    chk("t4_mask", o_mask, 16'h0010);
    chk("t4_err", o_err, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4_sticky", o_err, 1'b1);

    // Over-count
    do_reset();
    clr_pairs();
    for (int k = 0; k < 16; k++) pair(k, k, 16'h0100 + 16'(k));
    send(20, 1'b1);
    @(negedge clk);
    chk("t5_mask", o_mask, 16'hFFFF);
    chk("t5_lane7", o_data[7*N +: N], 16'h0107);
    chk("t5_err", o_err, 1'b1);

    // Reset mid-operation
    do_reset();
    i_ready = 1'b0;
    clr_pairs();
    pair(0, 9, 16'h0009);
    pair(1, 9, 16'h0019);
    send(2, 1'b1);
    clr_pairs();
    pair(0, 7, 16'h0077);
    send(1, 1'b0);
    do_reset();
    @(negedge clk);
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_bcnt", o_brick_cnt, '0);
    chk("t6_err", o_err, 1'b0);
    @(posedge clk);
    #1 i_ready = 1'b1;
    clr_pairs();
    pair(0, 3, 16'h0055);
    send(1, 1'b1);
    @(negedge clk);
    exp_d = '0;
    exp_d[3*N +: N] = 16'h0055;
    chk("t6_mask", o_mask, 16'h0008);
    chk("t6_data", o_data, exp_d);

    // Randomized traffic
    do_reset();
    took = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      took = i_valid && o_ready && !rst;
      @(posedge clk);
      #1;
      rst     = ($urandom_range(0, 399) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid || took) begin
        i_valid = ($urandom_range(0, 9) < 7);
        i_last  = ($urandom_range(0, 9) < 6);
        i_cnt   = ($urandom_range(0, 29) == 0) ? CS'($urandom_range(17, 31))
                                               : CS'($urandom_range(0, 16));
        st = $urandom_range(0, 15);
        for (int k = 0; k < TN; k++) begin
          if ($urandom_range(0, 19) == 0)
            i_idx[k*OS +: OS] = OS'($urandom_range(0, 15));
          else
            i_idx[k*OS +: OS] = OS'((st + k) % 16);
          i_data[k*N +: N] = N'($urandom);
        end
      end
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
